fetch_prefetch_buffer: RTL
==========================

Name: fetch_prefetch_buffer

Overview:
Instruction prefetch stage placed between the variable-latency instruction memory port and the IF2ID pipeline register. It runs ahead of the pipeline: it fetches sequential words into a small FIFO and presents one instruction per cycle, together with its PC+4, to IF2ID. It honours freeze (hazard stall) from the pipeline. On a redirect (branch/jump/jr resolved in ID) it flushes its contents, drops any in-flight response and restarts at the new PC.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
redirect  in  1  taken branch/jump from ID; highest priority
redirect_pc  in  32  new fetch address, used when redirect=1
freeze  in  1  pipeline stall; head entry is not consumed
imem_req  out  1  memory request, registered
imem_addr  out  32  word address of the request, registered
imem_ack  in  1  response valid this cycle
imem_rdata  in  32  instruction word, valid with imem_ack
valid  out  1  head entry present (FIFO not empty)
instruction  out  32  head instruction; 32'h0 (nop) when empty
PCplus4  out  32  head entry PC + 4; 0 when empty
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async): state=IDLE, fetch_pc=RESET_PC, FIFO empty, count=0, imem_req=0, imem_addr=RESET_PC, valid=0, instruction=0, PCplus4=0.
- FIFO entry holds {pc, instr}. Outputs are driven combinationally from the head entry.
- Pop: when valid && !freeze. Push: when an ack is accepted in REQ. Simultaneous push and pop: count unchanged, no overflow.
- FSM:
  - IDLE: if !redirect && count<DEPTH, go to REQ. On that edge imem_req<=1 and imem_addr<=fetch_pc.
  - REQ: imem_req and imem_addr are held stable until imem_ack (ack in the same cycle as req is legal). On ack: push {fetch_pc, imem_rdata}, fetch_pc+=4. Stay in REQ with imem_addr<=fetch_pc+4 if count_next<DEPTH; otherwise go to IDLE with imem_req<=0.
  - DISCARD: req held with the stale address until ack; the data is dropped; then go to IDLE with imem_req<=0.
- Redirect (any state) clears the FIFO (count=0, valid=0 next cycle), overrides any pop/push, and sets fetch_pc<=redirect_pc. Next state:
  - REQ without ack this cycle: DISCARD.
  - REQ with ack this cycle: response dropped, go to IDLE.
  - DISCARD: stay in DISCARD.
  - IDLE: stay in IDLE.
- Latency: with zero-wait memory (ack same cycle as req), the first valid instruction appears 2 cycles after reset release. Steady state delivers 1 instr/cycle; a redirect costs 2 bubble cycles, plus the remaining in-flight latency.
- fetch_pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- count never exceeds DEPTH. With a full FIFO and freeze held, no request is issued.
- Only one request is outstanding at any time.

Optional Feature:
FETCH_PREFETCH_STATS_EN: when defined, adds two output ports. drop_cnt [15:0] counts responses discarded due to redirect. stall_cnt [15:0] counts cycles with valid && freeze. Both saturate at 16'hFFFF and are cleared by rst. When undefined, the ports and logic do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory returning instr = addr|32'hA000_0000, freeze=0 -> valid at cycle 2; instructions A000_0000, A000_0004, A000_0008 on consecutive cycles; PCplus4 = 4, 8, 12.
- freeze=1 for 10 cycles from the start -> count reaches 4, imem_req=0, head stays A000_0000; release -> 4 back-to-back pops, then refill.
- Memory with 3-cycle ack latency, redirect to 32'h0000_0100 one cycle after req -> state DISCARD, stale ack dropped, next imem_addr=0x100, first delivered PCplus4=0x104.
- Redirect to 32'h40 coinciding with ack and pop -> FIFO empty next cycle, the acked word never appears, fetch resumes at 0x40.
- RESET_PC=32'hFFFF_FFF8, two fetches -> imem_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted mid-REQ with count=3 -> outputs return to reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer between the instruction memory port and IF2ID.
// It fetches sequential words ahead of the pipeline into a small FIFO and
// presents the head instruction with its PC+4. A redirect flushes the FIFO,
// drops any in-flight response and restarts fetching at the new PC.
// Optional statistics counters are enabled with `define FETCH_PREFETCH_STATS_EN.
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     freeze,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     valid,
    output logic [31:0]              instruction,
    output logic [31:0]              PCplus4,
    output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_PREFETCH_STATS_EN
    ,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // IDLE: no request outstanding; REQ: live request; DISCARD: stale request
    // whose response must be thrown away.
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t         state, state_next;
    logic [31:0]    fetch_pc, fetch_pc_next;
    logic           req_next;
    logic [31:0]    addr_next;
    logic           push, pop;
    logic [CW-1:0]  count_next;
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [31:0]    pc_mem    [DEPTH];
    logic [31:0]    instr_mem [DEPTH];

    // Head entry drives the outputs; an empty FIFO presents a nop.
    always_comb begin
        valid       = (count != '0);
        instruction = valid ? instr_mem[rd_ptr] : 32'h0;
        PCplus4     = valid ? pc_mem[rd_ptr] + 32'd4 : 32'h0;
    end

    // Next-state logic; redirect beats every other event.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_next    = state;
        req_next      = imem_req;
        addr_next     = imem_addr;
        fetch_pc_next = fetch_pc;
        push          = (state == REQ) && imem_ack && !redirect;
        pop           = valid && !freeze && !redirect;
        count_next    = count + CW'(push) - CW'(pop);

        if (redirect) begin
            fetch_pc_next = redirect_pc;
            unique case (state)
                IDLE:    state_next = IDLE;
                REQ: begin
                    if (imem_ack) begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end else begin
                        state_next = DISCARD;
                    end
                end
                DISCARD: begin
                    // The outstanding request completes here even while
                    // redirected again; waiting for a second ack would hang.
                    if (imem_ack) begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    if (count < CW'(DEPTH)) begin
                        state_next = REQ;
                        req_next   = 1'b1;
                        addr_next  = fetch_pc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        fetch_pc_next = fetch_pc + 32'd4;
                        if (count_next < CW'(DEPTH)) begin
                            addr_next = fetch_pc + 32'd4;
                        end else begin
                            state_next = IDLE;
                            req_next   = 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM state, fetch PC and the registered memory request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            imem_req  <= req_next;
            imem_addr <= addr_next;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    // FIFO storage writes on push.
    // NOTE: storage has no reset; occupancy gates every read, so stale
    // contents are never observable and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PREFETCH_STATS_EN
    logic drop_evt;
    logic stall_evt;
    assign drop_evt  = imem_ack && (((state == REQ) && redirect) || (state == DISCARD));
    assign stall_evt = valid && freeze;

    // Saturating counters of dropped responses and frozen cycles with data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt  <= 16'h0;
            stall_cnt <= 16'h0;
        end else begin
            if (drop_evt && (drop_cnt != 16'hFFFF))   drop_cnt  <= drop_cnt + 16'd1;
            if (stall_evt && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
